// File: rtl/eq_output_stage.sv
// Output stage of the EQ: rounding attenuation shift, saturation to 16-bit PCM,
// a small first-word-fall-through FIFO towards the DAC, and clip monitoring.
module eq_output_stage #(
  parameter int SHIFT = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      sig_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  input  logic             clip_clr,
  output logic             clip_flag,
  output logic [CNT_W-1:0] clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [32:0] ROUND   = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] PCM_MAX = 33'sd32767;
  localparam logic signed [32:0] PCM_MIN = -33'sd32768;

  logic [31:0]      p1_data_reg;
  logic             p1_valid_reg;
  logic [15:0]      p2_data_reg;
  logic             p2_valid_reg;
  logic             p2_clip_reg;

  logic signed [32:0] sum_ext;
  logic signed [32:0] shifted;
  logic [15:0]        sat_next;
  logic               clip_next;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [CW:0]      occupancy;
  logic             accept;
  logic             push;
  logic             pop;
  logic             clip_push;
  logic             clip_flag_reg;
  logic [CNT_W-1:0] clip_count_reg;

  // Every word past the acceptance point is counted against the FIFO space,
  // so the pipeline can run without ever stalling.
  assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, p1_valid_reg} + {{CW{1'b0}}, p2_valid_reg};
  assign in_ready  = occupancy < (CW + 1)'(DEPTH);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_reg <= 1'b0;
      p1_data_reg  <= '0;
    end else begin
      p1_valid_reg <= accept;
      if (accept) begin
        p1_data_reg <= sig_out;
      end
    end
  end

  // 33-bit add keeps the rounding constant from overflowing near full scale.
  always_comb begin
    sum_ext   = $signed({p1_data_reg[31], p1_data_reg}) + ROUND;
    shifted   = sum_ext >>> SHIFT;
    sat_next  = shifted[15:0];
    clip_next = 1'b0;
    if (shifted > PCM_MAX) begin
      sat_next  = 16'h7fff;
      clip_next = 1'b1;
    end else if (shifted < PCM_MIN) begin
      sat_next  = 16'h8000;
      clip_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p2_valid_reg <= 1'b0;
      p2_data_reg  <= '0;
      p2_clip_reg  <= 1'b0;
    end else begin
      p2_valid_reg <= p1_valid_reg;
      if (p1_valid_reg) begin
        p2_data_reg <= sat_next;
        p2_clip_reg <= clip_next;
      end
    end
  end

  assign push      = p2_valid_reg;
  assign out_valid = count_reg != '0;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr_reg] : 16'h0000;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == AW'(gi)) begin
        mem[gi] <= p2_data_reg;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // A clear colliding with a clip push keeps that new clip event.
  assign clip_push = push && p2_clip_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_flag_reg  <= 1'b0;
      clip_count_reg <= '0;
    end else if (clip_clr && clip_push) begin
      clip_flag_reg  <= 1'b1;
      clip_count_reg <= CNT_W'(1);
    end else if (clip_clr) begin
      clip_flag_reg  <= 1'b0;
      clip_count_reg <= '0;
    end else if (clip_push) begin
      clip_flag_reg <= 1'b1;
      if (clip_count_reg != {CNT_W{1'b1}}) begin
        clip_count_reg <= clip_count_reg + 1'b1;
      end
    end
  end

  assign clip_flag  = clip_flag_reg;
  assign clip_count = clip_count_reg;

endmodule

// File: tb/tb_eq_output_stage.sv
// Bench for eq_output_stage: directed and random traffic scored against a
// transaction-level model (outstanding-word queue with arrival times).
module tb_eq_output_stage;

  localparam int SHIFT = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      sig_out;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             clip_clr;
  logic             clip_flag;
  logic [CNT_W-1:0] clip_count;

  eq_output_stage #(.SHIFT(SHIFT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .sig_out(sig_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clip_clr(clip_clr), .clip_flag(clip_flag), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint expv;
    bit     clip;
    int     avail;
  } item_t;

  item_t q[$];
  int    clip_cnt_m;
  bit    clip_flag_m;
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Round half-up then divide by 2^SHIFT with floor semantics, then clamp.
  function automatic longint model_pcm(input int x, output bit clip);
    longint n, d, r;
    n = longint'(x) + (longint'(1) << (SHIFT - 1));
    d = longint'(1) << SHIFT;
    r = n / d;
    if ((n % d) != 0 && n < 0) r = r - 1;
    clip = 1'b0;
    if (r > 32767) begin
      r = 32767; clip = 1'b1;
    end else if (r < -32768) begin
      r = -32768; clip = 1'b1;
    end
    return r;
  endfunction

  // One cycle: drive at the falling edge, score, then advance to the next falling edge.
  task automatic step(input bit iv, input int d, input bit ordy, input bit clr);
    bit    exp_ready, exp_valid, acc, pop, cpush;
    item_t it;
    in_valid = iv; sig_out = d; out_ready = ordy; clip_clr = clr;
    #1;
    exp_ready = q.size() < DEPTH;
    exp_valid = (q.size() != 0) && (q[0].avail <= cyc);
    check("in_ready", longint'(in_ready), longint'(exp_ready));
    check("out_valid", longint'(out_valid), longint'(exp_valid));
    if (exp_valid) check("out_data", longint'($signed(out_data)), q[0].expv);
    acc = iv && exp_ready;
    pop = ordy && exp_valid;
    if (pop) it = q.pop_front();
    if (acc) begin
      it.expv  = model_pcm(d, it.clip);
      it.avail = cyc + 3;
      q.push_back(it);
    end
    @(negedge clk);
    cpush = 1'b0;
    foreach (q[i]) if (q[i].avail == cyc && q[i].clip) cpush = 1'b1;
    if (clr) begin
      clip_cnt_m  = cpush ? 1 : 0;
      clip_flag_m = cpush;
    end else if (cpush) begin
      clip_flag_m = 1'b1;
      if (clip_cnt_m < (1 << CNT_W) - 1) clip_cnt_m++;
    end
    check("clip_count", longint'(clip_count), longint'(clip_cnt_m));
    check("clip_flag", longint'(clip_flag), longint'(clip_flag_m));
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; clip_clr = 1'b0; sig_out = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    clip_cnt_m  = 0;
    clip_flag_m = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_clip_count", longint'(clip_count), 0);
    check("rst_clip_flag", longint'(clip_flag), 0);
  endtask

  function automatic int rand_word();
    int edges[6];
    edges = '{262139, 262140, -262148, -262149, 300000, -300000};
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 4000)) - 2000;
      1: return int'($urandom_range(0, 600000)) - 300000;
      2: return int'($urandom);
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  int rnd_vals[6];
  int sat_vals[3];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clip_clr = 1'b0; sig_out = '0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Mid-operation reset with three buffered words; none may emerge afterwards.
    for (int i = 0; i < 3; i++) step(1'b1, 1000 + 8 * i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);

    rnd_vals = '{800, 12, -12, -4, 3, 0};
    for (int i = 0; i < 5; i++) step(1'b1, rnd_vals[i], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);

    sat_vals = '{300000, -300000, 262139};
    for (int i = 0; i < 3; i++) step(1'b1, sat_vals[i], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("sat_clip_count", longint'(clip_count), 2);
    check("sat_clip_flag", longint'(clip_flag), 1);

    // Backpressure: only DEPTH words fit while the sink is stalled.
    for (int i = 1; i <= 6; i++) begin
      while (1) begin
        bit took;
        took = (q.size() < DEPTH) && !(i > DEPTH && cyc < 0);
        step(1'b1, 8 * i, (cyc > 60) ? 1'b1 : 1'b0, 1'b0);
        if (took) break;
        if (q.size() >= DEPTH && cyc > 200) break;
      end
      if (i == DEPTH) begin
        for (int k = 0; k < 5; k++) step(1'b1, 8 * (i + 1), 1'b0, 1'b0);
        step(1'b1, 8 * (i + 1), 1'b1, 1'b0);
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0);

    // Sustained stream: one word per cycle in and out.
    for (int i = 0; i < 20; i++) step(1'b1, 16 * i - 100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);

    // Clear colliding with a clip push at clip_count=5, then a plain clear.
    step(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 400000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("pre_clr_count", longint'(clip_count), 5);
    step(1'b1, -400000, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1);
    check("collide_count", longint'(clip_count), 1);
    check("collide_flag", longint'(clip_flag), 1);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1);
    check("clr_count", longint'(clip_count), 0);
    check("clr_flag", longint'(clip_flag), 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("drain_empty", longint'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
